caravel_uart_wb: RTL and testbench

Wishbone-slave 8N1 UART for the Caravel user project area, clocked from the 50 MHz Caravel clock. The management SoC reaches it over the user Wishbone bus at base 0x3000_0000. It drives TX on user pad io[16] and samples RX from pad io[15]. Firmware uses it to exchange bytes with an external host at 115200 baud by default (divisor 434).

---
 rtl/caravel_uart_pkg.sv | 20 ++
 rtl/uart_bit_engine.sv | 54 +++++
 rtl/caravel_uart_wb.sv | 182 ++++++++++++++++++
 tb/tb_caravel_uart_wb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_uart_pkg.sv
// Shared definitions for the Caravel Wishbone UART: register offsets,
// STATUS bit positions, the frame FSM encoding and the divisor floor.
package caravel_uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_BAUD   = 4'hC;
  localparam logic [7:0] OFF_IE     = 8'h10;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  localparam logic [23:0] MIN_DIV = 24'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_bit_engine.sv
// Frame sequencer shared by TX and RX: divisor counter, bit counter and the
// IDLE->START->DATA(x8)->STOP state. tick marks the last cycle of each bit.
module uart_bit_engine
  import caravel_uart_pkg::*;
#(
  parameter bit HALF_START = 1'b0
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        go,
  input  logic        abort,
  input  logic [23:0] div,
  output uart_state_t state,
  output logic [2:0]  bit_idx,
  output logic        tick
);

  logic [23:0] cnt;
  logic [23:0] per;

  assign tick = (state != IDLE) && (cnt == per - 24'd1);

  // Period is latched per bit so a divisor change lands on a bit boundary;
  // the receiver's first period is half a bit to reach the start-bit centre.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state   <= IDLE;
      cnt     <= '0;
      per     <= '0;
      bit_idx <= '0;
    end else if (state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (go) begin
        state <= START;
        per   <= HALF_START ? {1'b0, div[23:1]} : div;
      end
    end else if (tick) begin
      cnt <= '0;
      per <= div;
      case (state)
        START: state <= abort ? IDLE : DATA;
        DATA: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        default: state <= IDLE;
      endcase
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/caravel_uart_wb.sv
// Wishbone slave 8N1 UART for the Caravel user area. Defining UART_IRQ_EN adds
// irq_o and the IE register at offset 0x10.
module caravel_uart_wb
  import caravel_uart_pkg::*;
#(
  parameter logic [23:0] BAUD_DIV_RST = 24'd434,
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [1:0]  uart_oeb_o
`ifdef UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  function automatic logic [23:0] clamp_div(input logic [23:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic logic [23:0] baud_merge(input logic [23:0] cur,
                                             input logic [31:0] d,
                                             input logic [3:0]  s);
    logic [23:0] m;
    m = cur;
    for (int i = 0; i < 3; i++)
      if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    return clamp_div(m);
  endfunction

  logic        wb_hold, req, rd, wr, blk_hit;
  logic [3:0]  off;
  logic [31:0] rdata;
  logic [23:0] baud_div;
  logic [7:0]  tx_shift, rx_shift, rx_data;
  logic        rx_valid, rx_overrun, frame_err;
  logic        rx_meta, rx_s, rx_prev;
  logic        tx_go, tx_busy, tx_tick, rx_tick, rx_done, rx_rd, st_rd;
  logic [2:0]  tx_bit, rx_bit;
  uart_state_t tx_state, rx_state;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i[3], wbs_dat_i[31:24], rx_bit};
  assign uart_oeb_o  = 2'b01;

  // wb_hold blocks a second ack while the same strobe is still held.
  assign req     = wbs_cyc_i & wbs_stb_i & ~wb_hold;
  assign rd      = req & ~wbs_we_i;
  assign wr      = req & wbs_we_i;
  assign blk_hit = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign off     = wbs_adr_i[3:0];

  assign tx_busy = (tx_state != IDLE);
  assign tx_go   = wr & blk_hit & (off == OFF_TXDATA) & wbs_sel_i[0] & ~tx_busy;
  assign rx_rd   = rd & blk_hit & (off == OFF_RXDATA);
  assign st_rd   = rd & blk_hit & (off == OFF_STATUS);
  assign rx_done = rx_tick & (rx_state == STOP);

`ifdef UART_IRQ_EN
  localparam logic [27:0] IE_BLK = ADDR_BASE[31:4] + {24'd0, OFF_IE[7:4]};
  logic       ie_hit, tx_done;
  logic [1:0] ie;

  assign ie_hit = (wbs_adr_i[31:4] == IE_BLK) && (off == OFF_IE[3:0]);
  assign irq_o  = (ie[0] & rx_valid) | (ie[1] & tx_done);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      ie      <= '0;
      tx_done <= 1'b0;
    end else begin
      if (wr & ie_hit & wbs_sel_i[0]) ie <= wbs_dat_i[1:0];
      if (tx_tick && tx_state == STOP) tx_done <= 1'b1;
      else if (st_rd)                  tx_done <= 1'b0;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (blk_hit) begin
      case (off)
        OFF_RXDATA: rdata[7:0] = rx_data;
        OFF_STATUS: begin
          rdata[ST_TX_BUSY]    = tx_busy;
          rdata[ST_RX_VALID]   = rx_valid;
          rdata[ST_RX_OVERRUN] = rx_overrun;
          rdata[ST_FRAME_ERR]  = frame_err;
        end
        OFF_BAUD: rdata[23:0] = baud_div;
        default: ;
      endcase
    end
`ifdef UART_IRQ_EN
    if (ie_hit) rdata[1:0] = ie;
`endif
  end

  // Bus response and register side effects land together with the ack.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      wb_hold    <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      baud_div   <= BAUD_DIV_RST;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      wb_hold   <= wbs_cyc_i & wbs_stb_i;
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      rx_meta   <= uart_rx_i;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      if (wr && blk_hit && off == OFF_BAUD)
        baud_div <= baud_merge(baud_div, wbs_dat_i, wbs_sel_i);
      // A byte completing alongside an RXDATA read wins over the clear.
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rx_rd) rx_overrun <= 1'b1;
      else if (st_rd)                    rx_overrun <= 1'b0;
      if (rx_done && !rx_s) frame_err <= 1'b1;
      else if (st_rd)       frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_go) tx_shift <= wbs_dat_i[7:0];
    if (rx_tick && rx_state == DATA) rx_shift <= {rx_s, rx_shift[7:1]};
  end

  always_comb begin
    case (tx_state)
      START:   uart_tx_o = 1'b0;
      DATA:    uart_tx_o = tx_shift[tx_bit];
      default: uart_tx_o = 1'b1;
    endcase
  end

  uart_bit_engine #(.HALF_START(1'b0)) u_tx_engine (
    .clock   (clock),
    .resetb  (resetb),
    .go      (tx_go),
    .abort   (1'b0),
    .div     (baud_div),
    .state   (tx_state),
    .bit_idx (tx_bit),
    .tick    (tx_tick)
  );

  uart_bit_engine #(.HALF_START(1'b1)) u_rx_engine (
    .clock   (clock),
    .resetb  (resetb),
    .go      (rx_prev & ~rx_s),
    .abort   (rx_s),
    .div     (baud_div),
    .state   (rx_state),
    .bit_idx (rx_bit),
    .tick    (rx_tick)
  );

endmodule

// File: tb/tb_caravel_uart_wb.sv
// Scoreboard bench for caravel_uart_wb: Wishbone reads and decoded TX frames
// are checked against queued expectations by independent monitors.
module tb_caravel_uart_wb;

  localparam int          D    = 434;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        rx = 1'b1;
  logic        tx;
  logic [1:0]  oeb;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  bit mon_en = 1'b1;
  logic [31:0] rd_q[$];
  string       rd_n[$];
  logic [7:0]  tx_q[$];

  caravel_uart_wb dut (
    .clock      (clock),
    .resetb     (resetb),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .uart_rx_i  (rx),
    .uart_tx_o  (tx),
    .uart_oeb_o (oeb)
`ifdef UART_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Read monitor: every read ack pops the next expected value.
  always @(negedge clock) begin
    if (ack === 1'b1) begin
      ack_cnt++;
      if (!we) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %h want no read", dat_o);
        end else begin
          check(rd_n.pop_front(), dat_o, rd_q.pop_front());
        end
      end
    end
  end

  // TX monitor: samples each bit near both ends and compares the byte.
  initial begin : tx_mon
    logic [9:0] a, b;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        a = '0;
        b = '0;
        for (int c = 1; c <= 10*D-2; c++) begin
          @(negedge clock);
          if (c % D == 1)   a[c/D] = tx;
          if (c % D == D-2) b[c/D] = tx;
        end
        total++;
        if (tx_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got byte %h want none", a[8:1]);
        end else begin
          e = tx_q.pop_front();
          if (a !== b || a[0] !== 1'b0 || a[9] !== 1'b1 || a[8:1] !== e) begin
            bad++;
            $display("FAIL tx_frame: got bits %b/%b want byte %h", a, b, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wb(input logic w, input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + {24'd0, o}; dat = d; sel = s;
    do begin
      @(posedge clock); #1;
      n++;
    end while (ack !== 1'b1 && n < 8);
    if (ack !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wb_ack: got no ack want ack at offset %h", o);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic rd(input logic [7:0] o, input logic [31:0] exp, input string name);
    rd_q.push_back(exp);
    rd_n.push_back(name);
    wb(1'b0, o, 32'd0, 4'h1);
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
    wb(1'b1, o, d, s);
  endtask

  task automatic send(input logic [7:0] byte_v, input logic stop);
    logic [9:0] fr;
    fr = {stop, byte_v, 1'b0};
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (D) @(posedge clock);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 6000) begin
      @(posedge clock);
      n++;
    end
    if (n >= 6000) begin
      total++;
      bad++;
      $display("FAIL tx_drain: got %0d frames pending want 0", tx_q.size());
    end
    repeat (10) @(posedge clock);
    #1;
  endtask

  initial begin : stim
    logic [7:0] echo [6];
    int n0;
    echo = '{8'h64, 8'h65, 8'h20, 8'h31, 8'h62, 8'h32};

    repeat (4) @(posedge clock);
    #1;
    resetb = 1'b1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_dat", dat_o, 32'd0);
    check("reset_oeb", {30'd0, oeb}, 32'd1);
    rd(8'h08, 32'd0, "reset_status");
    rd(8'h0C, 32'd434, "reset_baud");
    rd(8'h04, 32'd0, "reset_rxdata");
    rd(8'h00, 32'd0, "txdata_reads_zero");
    rd(8'h10, 32'd0, "reg10_reset");

    // A strobe held for several cycles is acked once.
    n0 = ack_cnt;
    rd_q.push_back(32'd434);
    rd_n.push_back("held_read");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h0C; sel = 4'h1;
    repeat (5) @(posedge clock);
    #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("ack_once", ack_cnt - n0, 32'd1);

    wr(8'h0C, 32'd2, 4'h7);
    rd(8'h0C, 32'd4, "baud_clamp");
    wr(8'h0C, 32'd434, 4'h7);
    rd(8'h0C, 32'd434, "baud_restore");

    // 0x55 frame; the second write lands while busy and must be dropped.
    tx_q.push_back(8'h55);
    wr(8'h00, 32'h55, 4'h1);
    wr(8'h00, 32'hFF, 4'h1);
    repeat (4336) @(posedge clock);
    #1;
    rd(8'h08, 32'h1, "busy_last_cycle");
    rd(8'h08, 32'h0, "busy_dropped");
    wait_tx_idle();

    send(8'hA3, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    rd(8'h08, 32'h2, "rx_valid_set");
    rd(8'h04, 32'hA3, "rxdata_a3");
    rd(8'h08, 32'h0, "rx_valid_cleared");

    for (int i = 0; i < 6; i++) begin
      send(echo[i], 1'b1);
      repeat (20) @(posedge clock);
      #1;
      rd(8'h04, {24'd0, echo[i]}, "echo_rx");
      tx_q.push_back(echo[i]);
      wr(8'h00, {24'd0, echo[i]}, 4'h1);
    end
    wait_tx_idle();

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    rd(8'h08, 32'h6, "overrun_status");
    rd(8'h04, 32'h22, "overrun_rxdata");
    rd(8'h08, 32'h0, "overrun_cleared");

    send(8'h5A, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    rd(8'h08, 32'hA, "frame_err_status");
    rd(8'h04, 32'h5A, "frame_err_rxdata");
    rd(8'h08, 32'h0, "frame_err_cleared");

    rx = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (1000) @(posedge clock);
    #1;
    rd(8'h08, 32'h0, "glitch_status");
    rd(8'h04, 32'h5A, "glitch_rxdata");

`ifdef UART_IRQ_EN
    wr(8'h10, 32'h1, 4'h1);
    rd(8'h10, 32'h1, "ie_readback");
    check("irq_idle", {31'd0, irq}, 32'd0);
    send(8'h3C, 1'b1);
    check("irq_rx", {31'd0, irq}, 32'd1);
    rd(8'h04, 32'h3C, "irq_rxdata");
    check("irq_cleared", {31'd0, irq}, 32'd0);
`endif

    // Reset mid-frame releases the line on the following cycle.
    mon_en = 1'b0;
    wr(8'h00, 32'h00, 4'h1);
    repeat (100) @(posedge clock);
    #1;
    check("tx_midframe_low", {31'd0, tx}, 32'd0);
    resetb = 1'b0;
    @(posedge clock);
    #1;
    check("tx_reset_abort", {31'd0, tx}, 32'd1);
    resetb = 1'b1;
    rd(8'h08, 32'h0, "status_after_reset");
    rd(8'h0C, 32'd434, "baud_after_reset");

    repeat (5) @(posedge clock);
    check("rd_queue_empty", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
